// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests over a
// req/ack handshake and presents fetched words to the decoder through an
// output entry backed by a one-word skid entry. Redirects squash wrong-path
// words, including a word that is still in flight when the redirect arrives.
`timescale 1ns/1ps

module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        armed_q, armed_d;       // one settling cycle spent in IDLE
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_pc4_q, out_pc4_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        kill_q, kill_d;         // in-flight word belongs to a squashed path

    logic        ack_s;
    logic        consume_s;
    logic [31:0] target_s;

    // Next-state logic: request sequencing, buffer movement and redirect flush.
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        pc_d         = pc_q;
        req_d        = req_q;
        addr_d       = addr_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_pc4_d    = out_pc4_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        kill_d       = kill_q;

        ack_s     = imem_ack & req_q;
        consume_s = out_valid_q & ~stall;
        target_s  = redirect_target & 32'hFFFF_FFFC;

        // A consumed entry empties unless refilled below.
        if (consume_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                req_d = 1'b0;
                if (redirect_valid) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                if (armed_q) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_d;
                end else begin
                    armed_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    if (redirect_valid || kill_q) begin
                        // Wrong-path word: drop it and fetch from the current PC.
                        kill_d = 1'b0;
                        if (redirect_valid) begin
                            pc_d = target_s;
                        end else begin
                            pc_d = pc_q;
                        end
                        addr_d = pc_d;
                    end else if (!out_valid_q || consume_s) begin
                        out_valid_d = 1'b1;
                        out_instr_d = imem_rdata;
                        out_pc_d    = addr_q;
                        out_pc4_d   = addr_q + 32'd4;
                        pc_d        = pc_q + 32'd4;
                        addr_d      = pc_q + 32'd4;
                    end else begin
                        // Output blocked: park the word and stop fetching.
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = addr_q;
                        pc_d         = pc_q + 32'd4;
                        req_d        = 1'b0;
                        state_d      = ST_FULL;
                    end
                end else begin
                    // Request cannot be cancelled; remember to discard its data.
                    if (redirect_valid) begin
                        kill_d = 1'b1;
                        pc_d   = target_s;
                    end else begin
                        kill_d = kill_q;
                    end
                end
            end
            ST_FULL: begin
                if (redirect_valid) begin
                    pc_d    = target_s;
                    addr_d  = target_s;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end else if (consume_s) begin
                    out_valid_d  = 1'b1;
                    out_instr_d  = skid_instr_q;
                    out_pc_d     = skid_pc_q;
                    out_pc4_d    = skid_pc_q + 32'd4;
                    skid_valid_d = 1'b0;
                    req_d        = 1'b1;
                    addr_d       = pc_q;
                    state_d      = ST_REQ;
                end else begin
                    req_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // Redirect wins over stall and consumption: flush both entries.
        if (redirect_valid) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            skid_valid_d = skid_valid_d;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_instr_q  <= 32'h0000_0000;
            out_pc_q     <= 32'h0000_0000;
            out_pc4_q    <= 32'h0000_0000;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0000_0000;
            skid_pc_q    <= 32'h0000_0000;
            kill_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_pc4_q    <= out_pc4_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            kill_q       <= kill_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = out_valid_q;
    assign instruction = out_instr_q;
    assign instr_pc    = out_pc_q;
    assign pc_plus4    = out_pc4_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, wrap and
// async-reset sequences, then random traffic against a buffer-level model.
`timescale 1ns/1ps

module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ack = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0000_0000;

    logic        req_m, valid_m, req_w, valid_w;
    logic [31:0] addr_m, instr_m, ipc_m, pc4_m, rdata_m;
    logic [31:0] addr_w, instr_w, ipc_w, pc4_w, rdata_w;

    int errors = 0;
    int checks = 0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign rdata_m = mem_word(addr_m);
    assign rdata_w = mem_word(addr_w);

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem_req(req_m), .imem_addr(addr_m),
        .imem_ack(imem_ack), .imem_rdata(rdata_m), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_valid(valid_m), .instruction(instr_m), .instr_pc(ipc_m),
        .pc_plus4(pc4_m));

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(imem_ack), .imem_rdata(rdata_w), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_valid(valid_w), .instruction(instr_w), .instr_pc(ipc_w),
        .pc_plus4(pc4_w));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        ack;
        logic        stl;
        logic        redir;
        logic [31:0] tgt;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
    } vec_t;

    vec_t tab [18];

    task automatic set_vec(input int i, input logic a, input logic s, input logic r,
                           input logic [31:0] t, input logic er, input logic [31:0] ea,
                           input logic ev, input logic [31:0] ep);
        tab[i] = '{ack: a, stl: s, redir: r, tgt: t, ereq: er, eaddr: ea, evalid: ev, epc: ep};
    endtask

    // ---------------- reference model ----------------
    // Buffer = queue of presented PCs (head is what the decoder sees, at most 2).
    logic [31:0] m_q [$];
    logic        m_req, m_kill, m_armed;
    logic [31:0] m_addr, m_pc;

    task automatic model_reset(input logic [31:0] rpc);
        m_q.delete();
        m_req = 1'b0; m_kill = 1'b0; m_armed = 1'b0;
        m_addr = rpc; m_pc = rpc;
    endtask

    task automatic model_step(input logic ack, input logic stl, input logic redir,
                              input logic [31:0] tgt);
        logic        got;
        logic [31:0] npc;
        got = ack && m_req;
        npc = redir ? (tgt & 32'hFFFF_FFFC) : m_pc;
        if (redir) m_q.delete();
        else if (m_q.size() > 0 && !stl) void'(m_q.pop_front());
        if (got) begin
            if (!redir && !m_kill) begin
                m_q.push_back(m_addr);
                npc = m_pc + 32'd4;
            end
            m_kill = 1'b0;
        end else if (redir && m_req) begin
            m_kill = 1'b1;
        end
        // Fetch whenever the buffer has room and no request is still waiting.
        if (!m_armed) begin
            m_armed = 1'b1;
            m_req   = 1'b0;
        end else if (m_req && !got) begin
            m_req = 1'b1;
        end else if (m_q.size() < 2) begin
            m_req  = 1'b1;
            m_addr = npc;
        end else begin
            m_req = 1'b0;
        end
        m_pc = npc;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        imem_ack = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_edge;
        logic a, s, r;
        logic [31:0] t;

        set_vec(0,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0);
        set_vec(1,  1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0);
        set_vec(2,  1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0);
        set_vec(3,  1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4);
        set_vec(4,  1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8);
        set_vec(5,  1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8);
        set_vec(6,  1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8);
        set_vec(7,  1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8);
        set_vec(8,  1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC);
        set_vec(9,  1'b0, 1'b0, 1'b1, 32'h40,  1'b1, 32'h10,  1'b0, 32'h0);
        set_vec(10, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0);
        set_vec(11, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  1'b0, 32'h0);
        set_vec(12, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h44,  1'b1, 32'h40);
        set_vec(13, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h40);
        set_vec(14, 1'b0, 1'b1, 1'b1, 32'h103, 1'b1, 32'h100, 1'b0, 32'h0);
        set_vec(15, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0);
        set_vec(16, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100);
        set_vec(17, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0);

        // Reset values
        do_reset();
        chk("rst_req", {31'd0, req_m}, 32'd0);
        chk("rst_addr", addr_m, 32'h0);
        chk("rst_valid", {31'd0, valid_m}, 32'd0);
        chk("rst_instr", instr_m, 32'h0);
        chk("rst_ipc", ipc_m, 32'h0);
        chk("rst_pc4", pc4_m, 32'h0);
        chk("rst_wrap_addr", addr_w, 32'hFFFF_FFFC);

        // Directed table: streaming, stall with skid, redirects
        for (int i = 0; i < 18; i++) begin
            imem_ack = tab[i].ack; stall = tab[i].stl;
            redirect_valid = tab[i].redir; redirect_target = tab[i].tgt;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_req", i), {31'd0, req_m}, {31'd0, tab[i].ereq});
            if (tab[i].ereq) chk($sformatf("vec%0d_addr", i), addr_m, tab[i].eaddr);
            chk($sformatf("vec%0d_valid", i), {31'd0, valid_m}, {31'd0, tab[i].evalid});
            if (tab[i].evalid) begin
                chk($sformatf("vec%0d_pc", i), ipc_m, tab[i].epc);
                chk($sformatf("vec%0d_instr", i), instr_m, mem_word(tab[i].epc));
                chk($sformatf("vec%0d_pc4", i), pc4_m, tab[i].epc + 32'd4);
            end
        end

        // Wrap-around from RESET_PC = FFFF_FFFC
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_req", {31'd0, req_w}, 32'd1);
        chk("wrap_addr0", addr_w, 32'hFFFF_FFFC);
        imem_ack = 1'b1;
        @(posedge clk); #1;
        chk("wrap_pc0", ipc_w, 32'hFFFF_FFFC);
        chk("wrap_pc4_0", pc4_w, 32'h0);
        chk("wrap_addr1", addr_w, 32'h0);
        @(posedge clk); #1;
        chk("wrap_pc1", ipc_w, 32'h0);
        chk("wrap_instr1", instr_w, mem_word(32'h0));
        chk("wrap_pc4_1", pc4_w, 32'h4);

        // Async reset mid-fetch (main DUT is streaming with req=1, valid=1)
        chk("pre_arst_valid", {31'd0, valid_m}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_req", {31'd0, req_m}, 32'd0);
        chk("arst_valid", {31'd0, valid_m}, 32'd0);
        chk("arst_addr", addr_m, 32'h0);
        imem_ack = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        n_edge = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (req_m && n_edge == 0) n_edge = k;
        end
        chk("arst_restart_edge", n_edge, 32'd2);
        chk("arst_restart_addr", addr_m, 32'h0);

        // Random traffic against the model
        do_reset();
        model_reset(32'h0000_0000);
        for (int c = 0; c < 2000; c++) begin
            a = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 19) == 0);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            imem_ack = a; stall = s; redirect_valid = r; redirect_target = t;
            @(posedge clk);
            model_step(a, s, r, t);
            #1;
            chk($sformatf("rnd%0d_req", c), {31'd0, req_m}, {31'd0, m_req});
            if (m_req) chk($sformatf("rnd%0d_addr", c), addr_m, m_addr);
            chk($sformatf("rnd%0d_valid", c), {31'd0, valid_m}, {31'd0, (m_q.size() > 0)});
            if (m_q.size() > 0) begin
                chk($sformatf("rnd%0d_pc", c), ipc_m, m_q[0]);
                chk($sformatf("rnd%0d_instr", c), instr_m, mem_word(m_q[0]));
                chk($sformatf("rnd%0d_pc4", c), pc4_m, m_q[0] + 32'd4);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
